// File: rtl/fetch_pc_gen.sv
// Fetch-stage PC generator: registered fetch PC, next-PC selection and a
// direct-mapped BTB that predicts the next fetch group address.
module fetch_pc_gen #(
  parameter logic [31:0] RESET_PC    = 32'hbfc0_0000,
  parameter int          FETCH_WIDTH = 1,
  parameter int          BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        exc_valid,
  input  logic [31:0] exc_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        btb_upd_valid,
  input  logic [31:0] btb_upd_pc,
  input  logic [31:0] btb_upd_target,
  input  logic        btb_upd_taken,
  output logic [31:0] f_pc,
  output logic        f_valid,
  output logic        f_adel,
  output logic [31:0] pred_pc,
  output logic        pred_taken
);

  localparam int GRP_BYTES = 4 * FETCH_WIDTH;
  localparam int OFS_W     = $clog2(GRP_BYTES);
  localparam int IDX_W     = $clog2(BTB_ENTRIES);
  localparam int TAG_W     = 32 - OFS_W - IDX_W;

  logic [BTB_ENTRIES-1:0] btb_valid;
  logic [TAG_W-1:0]       btb_tag    [BTB_ENTRIES];
  logic [31:0]            btb_target [BTB_ENTRIES];

  logic [IDX_W-1:0] look_idx;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] look_tag;
  logic [TAG_W-1:0] upd_tag;
  logic             hit;
  logic [31:0]      seq_pc;
  logic [31:0]      next_pc;
  logic             unused_upd_ofs;

  assign look_idx       = f_pc[OFS_W +: IDX_W];
  assign look_tag       = f_pc[31 -: TAG_W];
  assign upd_idx        = btb_upd_pc[OFS_W +: IDX_W];
  assign upd_tag        = btb_upd_pc[31 -: TAG_W];
  assign unused_upd_ofs = ^btb_upd_pc[OFS_W-1:0];

  assign f_adel = (f_pc[1:0] != 2'b00);
  assign seq_pc = {f_pc[31:OFS_W], {OFS_W{1'b0}}} + 32'(GRP_BYTES);

  // A misaligned fetch address raises an address error, so never predict from it.
  assign hit        = btb_valid[look_idx] && (btb_tag[look_idx] == look_tag) && !f_adel;
  assign pred_taken = hit;
  assign pred_pc    = hit ? btb_target[look_idx] : seq_pc;

  // The first cycle out of reset fetches RESET_PC itself rather than skipping past it.
  always_comb begin
    next_pc = pred_pc;
    if (exc_valid)
      next_pc = exc_pc;
    else if (redirect_valid)
      next_pc = redirect_pc;
    else if (stall || !f_valid)
      next_pc = f_pc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_pc    <= RESET_PC;
      f_valid <= 1'b0;
    end else begin
      f_pc    <= next_pc;
      f_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btb_valid <= '0;
    end else if (btb_upd_valid) begin
      if (btb_upd_taken)
        btb_valid[upd_idx] <= 1'b1;
      else if (btb_tag[upd_idx] == upd_tag)
        btb_valid[upd_idx] <= 1'b0;
    end
  end

  // Tag and target are qualified by the valid bit, so they need no reset.
  always_ff @(posedge clk) begin
    if (btb_upd_valid && btb_upd_taken) begin
      btb_tag[upd_idx]    <= upd_tag;
      btb_target[upd_idx] <= btb_upd_target;
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen: FETCH_WIDTH=1 and FETCH_WIDTH=4 instances share the
// stimulus and are compared each cycle against a group-address BTB model.
module tb_fetch_pc_gen;

  localparam logic [31:0] RST_PC = 32'hbfc0_0000;

  logic        clk, reset, stall, exc_valid, redirect_valid;
  logic        btb_upd_valid, btb_upd_taken;
  logic [31:0] exc_pc, redirect_pc, btb_upd_pc, btb_upd_target;
  logic [31:0] f_pc_1, pred_pc_1, f_pc_4, pred_pc_4;
  logic        f_valid_1, f_adel_1, pred_taken_1;
  logic        f_valid_4, f_adel_4, pred_taken_4;
  logic        cmp_en;

  int checks = 0;
  int errors = 0;

  fetch_pc_gen #(.RESET_PC(RST_PC), .FETCH_WIDTH(1), .BTB_ENTRIES(16)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .exc_valid(exc_valid), .exc_pc(exc_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .btb_upd_valid(btb_upd_valid), .btb_upd_pc(btb_upd_pc),
    .btb_upd_target(btb_upd_target), .btb_upd_taken(btb_upd_taken),
    .f_pc(f_pc_1), .f_valid(f_valid_1), .f_adel(f_adel_1),
    .pred_pc(pred_pc_1), .pred_taken(pred_taken_1)
  );

  fetch_pc_gen #(.RESET_PC(RST_PC), .FETCH_WIDTH(4), .BTB_ENTRIES(16)) dut4 (
    .clk(clk), .reset(reset), .stall(stall),
    .exc_valid(exc_valid), .exc_pc(exc_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .btb_upd_valid(btb_upd_valid), .btb_upd_pc(btb_upd_pc),
    .btb_upd_target(btb_upd_target), .btb_upd_taken(btb_upd_taken),
    .f_pc(f_pc_4), .f_valid(f_valid_4), .f_adel(f_adel_4),
    .pred_pc(pred_pc_4), .pred_taken(pred_taken_4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: index 0 is the 1-wide instance, index 1 the 4-wide one.
  // BTB entries remember the whole group address of the trained branch.
  logic [31:0] m_pc   [2];
  logic        m_val  [2];
  logic        m_bv   [2][16];
  logic [31:0] m_bgrp [2][16];
  logic [31:0] m_btgt [2][16];
  logic [31:0] m_nxt  [2];

  function automatic logic [31:0] gsz(input int c);
    return (c == 0) ? 32'd4 : 32'd16;
  endfunction

  function automatic logic [31:0] grp(input int c, input logic [31:0] pc);
    return pc - (pc % gsz(c));
  endfunction

  function automatic int bidx(input int c, input logic [31:0] pc);
    return int'((grp(c, pc) / gsz(c)) % 32'd16);
  endfunction

  function automatic logic m_hit(input int c);
    int i;
    i = bidx(c, m_pc[c]);
    return m_bv[c][i] && (m_bgrp[c][i] == grp(c, m_pc[c])) && ((m_pc[c] % 32'd4) == 32'd0);
  endfunction

  function automatic logic [31:0] m_pred(input int c);
    logic [31:0] s;
    s = grp(c, m_pc[c]) + gsz(c);
    return m_hit(c) ? m_btgt[c][bidx(c, m_pc[c])] : s;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < 2; c++) begin
        m_pc[c]  = RST_PC;
        m_val[c] = 1'b0;
        for (int i = 0; i < 16; i++) m_bv[c][i] = 1'b0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (exc_valid)               m_nxt[c] = exc_pc;
        else if (redirect_valid)     m_nxt[c] = redirect_pc;
        else if (stall || !m_val[c]) m_nxt[c] = m_pc[c];
        else                         m_nxt[c] = m_pred(c);
      end
      if (btb_upd_valid) begin
        for (int c = 0; c < 2; c++) begin
          int k;
          k = bidx(c, btb_upd_pc);
          if (btb_upd_taken) begin
            m_bv[c][k]   = 1'b1;
            m_bgrp[c][k] = grp(c, btb_upd_pc);
            m_btgt[c][k] = btb_upd_target;
          end else if (m_bv[c][k] && m_bgrp[c][k] == grp(c, btb_upd_pc)) begin
            m_bv[c][k] = 1'b0;
          end
        end
      end
      for (int c = 0; c < 2; c++) begin
        m_pc[c]  = m_nxt[c];
        m_val[c] = 1'b1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      checkOutput("w1_f_pc",       f_pc_1,              m_pc[0]);
      checkOutput("w1_f_valid",    32'(f_valid_1),      32'(m_val[0]));
      checkOutput("w1_f_adel",     32'(f_adel_1),       32'((m_pc[0] % 32'd4) != 32'd0));
      checkOutput("w1_pred_pc",    pred_pc_1,           m_pred(0));
      checkOutput("w1_pred_taken", 32'(pred_taken_1),   32'(m_hit(0)));
      checkOutput("w4_f_pc",       f_pc_4,              m_pc[1]);
      checkOutput("w4_f_valid",    32'(f_valid_4),      32'(m_val[1]));
      checkOutput("w4_f_adel",     32'(f_adel_4),       32'((m_pc[1] % 32'd4) != 32'd0));
      checkOutput("w4_pred_pc",    pred_pc_4,           m_pred(1));
      checkOutput("w4_pred_taken", 32'(pred_taken_4),   32'(m_hit(1)));
    end
  end

  task automatic applyStimulus(input logic s, input logic ev, input logic [31:0] epc,
                               input logic rv, input logic [31:0] rpc,
                               input logic uv, input logic [31:0] upc,
                               input logic [31:0] utgt, input logic ut);
    stall          = s;
    exc_valid      = ev;
    exc_pc         = epc;
    redirect_valid = rv;
    redirect_pc    = rpc;
    btb_upd_valid  = uv;
    btb_upd_pc     = upc;
    btb_upd_target = utgt;
    btb_upd_taken  = ut;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic redirectTo(input logic [31:0] pc);
    applyStimulus(0, 0, 0, 1, pc, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run did not complete, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    cmp_en = 1'b0;
    reset  = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 reset = 1'b1;
    #1;
    checkOutput("reset_f_pc",    f_pc_1,         32'hbfc00000);
    checkOutput("reset_f_valid", 32'(f_valid_1), 32'd0);
    #1 reset = 1'b0;
    cmp_en = 1'b1;

    // Free run from reset
    nextCycle();
    checkOutput("run0_f_pc",    f_pc_1,         32'hbfc00000);
    checkOutput("run0_f_valid", 32'(f_valid_1), 32'd1);
    checkOutput("run0_taken",   32'(pred_taken_1), 32'd0);
    nextCycle();
    checkOutput("run1_f_pc", f_pc_1, 32'hbfc00004);
    nextCycle();
    checkOutput("run2_f_pc", f_pc_1, 32'hbfc00008);

    // Stall, then redirect and exception overriding stall
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) begin
      nextCycle();
      checkOutput("stall_hold", f_pc_1, 32'hbfc00008);
    end
    applyStimulus(1, 0, 0, 1, 32'hbfc00100, 0, 0, 0, 0);
    nextCycle();
    checkOutput("redirect_over_stall", f_pc_1, 32'hbfc00100);
    applyStimulus(1, 1, 32'hbfc00380, 1, 32'hbfc00100, 0, 0, 0, 0);
    nextCycle();
    checkOutput("exc_over_redirect", f_pc_1, 32'hbfc00380);

    // Group arithmetic and 32-bit wrap
    redirectTo(32'hbfc00008);
    nextCycle();
    checkOutput("w4_group_seq", pred_pc_4, 32'hbfc00010);
    checkOutput("w1_seq",       pred_pc_1, 32'hbfc0000c);
    redirectTo(32'hfffffff0);
    nextCycle();
    checkOutput("w4_wrap", pred_pc_4, 32'h00000000);
    checkOutput("w1_near_wrap", pred_pc_1, 32'hfffffff4);
    redirectTo(32'hfffffffc);
    nextCycle();
    checkOutput("w1_wrap", pred_pc_1, 32'h00000000);

    // BTB train, follow, untrain
    applyStimulus(0, 0, 0, 1, 32'hbfc00010, 1, 32'hbfc00010, 32'hbfc00200, 1);
    nextCycle();
    checkOutput("train_taken", 32'(pred_taken_1), 32'd1);
    checkOutput("train_pred",  pred_pc_1,         32'hbfc00200);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    checkOutput("follow_target", f_pc_1, 32'hbfc00200);
    applyStimulus(0, 0, 0, 1, 32'hbfc00010, 1, 32'hbfc00010, 0, 0);
    nextCycle();
    checkOutput("untrain_taken", 32'(pred_taken_1), 32'd0);
    checkOutput("untrain_pred",  pred_pc_1,         32'hbfc00014);
    applyStimulus(0, 0, 0, 1, 32'hbfc00010, 1, 32'hbfc00010, 32'hbfc00200, 1);
    nextCycle();
    applyStimulus(0, 0, 0, 1, 32'hbfc00010, 1, 32'hbfc00050, 0, 0);
    nextCycle();
    checkOutput("other_tag_keeps", 32'(pred_taken_1), 32'd1);
    checkOutput("other_tag_pred",  pred_pc_1,         32'hbfc00200);

    // Aliasing index, then same-cycle update and lookup
    redirectTo(32'hbfc00050);
    nextCycle();
    checkOutput("alias_miss", 32'(pred_taken_1), 32'd0);
    checkOutput("alias_pred", pred_pc_1,         32'hbfc00054);
    applyStimulus(0, 0, 0, 1, 32'hbfc00010, 1, 32'hbfc00010, 0, 0);
    nextCycle();
    applyStimulus(1, 0, 0, 0, 0, 1, 32'hbfc00010, 32'hbfc00300, 1);
    #1;
    checkOutput("same_cycle_old",      32'(pred_taken_1), 32'd0);
    checkOutput("same_cycle_old_pred", pred_pc_1,         32'hbfc00014);
    nextCycle();
    checkOutput("same_cycle_new",      32'(pred_taken_1), 32'd1);
    checkOutput("same_cycle_new_pred", pred_pc_1,         32'hbfc00300);

    // Misaligned redirect suppresses a trained hit
    applyStimulus(0, 0, 0, 1, 32'hbfc00102, 1, 32'hbfc00100, 32'hbfc00400, 1);
    nextCycle();
    checkOutput("misalign_pc",    f_pc_1,            32'hbfc00102);
    checkOutput("misalign_adel",  32'(f_adel_1),     32'd1);
    checkOutput("misalign_taken", 32'(pred_taken_1), 32'd0);
    checkOutput("misalign_pred",  pred_pc_1,         32'hbfc00104);
    checkOutput("w4_misalign_adel", 32'(f_adel_4),   32'd1);
    redirectTo(32'hbfc00100);
    nextCycle();
    checkOutput("aligned_hit",  32'(pred_taken_1), 32'd1);
    checkOutput("aligned_pred", pred_pc_1,         32'hbfc00400);

    // Asynchronous reset between edges, mid-redirect and mid-update
    applyStimulus(0, 0, 0, 1, 32'hbfc00100, 1, 32'hbfc00100, 32'hbfc00400, 1);
    #1 reset = 1'b1;
    #1;
    checkOutput("async_f_pc",     f_pc_1,         32'hbfc00000);
    checkOutput("async_f_valid",  32'(f_valid_1), 32'd0);
    checkOutput("async_w4_f_pc",  f_pc_4,         32'hbfc00000);
    #1 reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    checkOutput("post_reset_pc",    f_pc_1,         32'hbfc00000);
    checkOutput("post_reset_valid", 32'(f_valid_1), 32'd1);
    redirectTo(32'hbfc00100);
    nextCycle();
    checkOutput("btb_cleared_a", 32'(pred_taken_1), 32'd0);
    redirectTo(32'hbfc00010);
    nextCycle();
    checkOutput("btb_cleared_b", 32'(pred_taken_1), 32'd0);

    // Mixed directed sequence checked by the per-cycle model comparison
    for (int i = 0; i < 48; i++) begin
      logic [31:0] rpc;
      rpc = RST_PC + 32'(i) * 32'h40 + ((i % 11 == 0) ? 32'd2 : 32'd0);
      applyStimulus(i % 5 == 3, i == 20, 32'hbfc00380,
                    i % 7 == 0, rpc,
                    i % 3 == 0, RST_PC + 32'((i % 8) * 16),
                    RST_PC + 32'h1000 + 32'(i) * 32'd4, i % 4 != 1);
      nextCycle();
    end

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_pc_gen.md
Name: fetch_pc_gen

Overview:
Parametrised fetch-stage PC generator. It holds the current fetch PC and selects the next PC from four sources: exception vector, backend redirect, stall hold, or prediction. The prediction uses a direct-mapped BTB, falling back to the sequential group address. It sits at the head of the fetch stage, drives the I-cache request address, and supplies the predicted next PC to decode.

Parameters:
RESET_PC, 32'hbfc0_0000, fetch PC loaded on reset.
FETCH_WIDTH, 1, instructions per fetch group; legal values 1, 2, 4.
BTB_ENTRIES, 16, BTB entry count; power of 2, minimum 2.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous reset, active-high.
stall  in  1  hold f_pc (fetch stage stalled).
exc_valid  in  1  exception/eret redirect request.
exc_pc  in  32  exception target.
redirect_valid  in  1  branch-mispredict redirect from execute.
redirect_pc  in  32  corrected target.
btb_upd_valid  in  1  BTB update strobe from execute.
btb_upd_pc  in  32  fetch-group address of the resolved branch.
btb_upd_target  in  32  resolved target.
btb_upd_taken  in  1  branch was taken.
f_pc  out  32  current fetch PC (registered).
f_valid  out  1  f_pc is a real fetch request.
f_adel  out  1  f_pc[1:0] != 0 (fetch address error).
pred_pc  out  32  predicted next fetch PC (combinational from f_pc and BTB).
pred_taken  out  1  pred_pc came from a BTB hit.

Behaviour:
- Reset (async, any time, including mid-redirect or mid-update):
  - f_pc = RESET_PC, f_valid = 0, all BTB valid bits cleared.
  - f_valid rises at the first clk edge after reset deasserts; it stays 1 thereafter.
- Geometry:
  - G = 4*FETCH_WIDTH bytes.
  - group(pc) = pc with the low log2(G) bits cleared.
  - seq(pc) = group(pc) + G, 32-bit wrap: 32'hffff_fffc with FETCH_WIDTH=1 gives 0.
- BTB lookup:
  - idx = f_pc[log2(G) +: log2(BTB_ENTRIES)]; tag = f_pc[31 : log2(G)+log2(BTB_ENTRIES)].
  - hit = entry valid && tag match && !f_adel.
  - pred_taken = hit; pred_pc = hit ? entry target : seq(f_pc).
  - Zero-cycle latency (combinational).
- Next-PC priority, applied at each clk edge:
  1. exc_valid -> exc_pc.
  2. redirect_valid -> redirect_pc.
  3. stall -> f_pc unchanged.
  4. otherwise pred_pc.
- exc_valid and redirect_valid both override stall. Simultaneous exc and redirect: exc wins.
- Redirect targets are loaded unmodified, even if misaligned.
- f_adel = (f_pc[1:0] != 0), combinational. A misaligned f_pc never produces a BTB hit.
- BTB update at the clk edge when btb_upd_valid, indexed/tagged from btb_upd_pc:
  - taken: write valid=1, tag, target (overwrite).
  - not taken: clear valid only if the entry is valid and its tag matches; otherwise no change.
- Update is independent of stall and redirects.
- Same-cycle lookup and update of the same idx: lookup sees old contents; the new contents are visible from the next cycle.
- No other state. Outputs change only on clk or reset, except the combinational pred_pc, pred_taken and f_adel.

Test Plan:
1. Reset then run, FETCH_WIDTH=1, no stall/redirect: reset -> f_pc=bfc00000, f_valid=0; subsequent cycles f_pc = bfc00000, bfc00004, bfc00008, with f_valid=1 from the first edge; pred_taken=0 throughout.
2. Stall vs redirect: stall=1 for 3 cycles holds f_pc=bfc00008. Next cycle stall=1 with redirect_valid=1 and redirect_pc=bfc00100 -> f_pc=bfc00100. Same cycle exc_valid=1 with exc_pc=bfc00380 plus redirect -> f_pc=bfc00380.
3. BTB train/hit/untrain:
   - Update pc=bfc00010, target=bfc00200, taken=1 -> once f_pc=bfc00010, pred_taken=1, pred_pc=bfc00200 and next f_pc=bfc00200.
   - Update same pc with taken=0 -> hit cleared next cycle.
   - Not-taken update on a different tag with the same idx leaves the entry intact.
4. Aliasing and same-cycle: with BTB_ENTRIES=16, pc bfc00010 and bfc00050 share idx 4.
   - Train the first, look up the second -> miss.
   - Update and lookup of bfc00010 in the same cycle -> old result that cycle, new result next cycle.
5. FETCH_WIDTH=4: f_pc=bfc00008 -> pred_pc=bfc00010 (group-aligned). Wrap case: f_pc=fffffff0 -> pred_pc=00000000.
6. Misalignment and async reset: redirect_pc=bfc00102 -> f_adel=1, pred_taken=0 even when an entry trained for bfc00100 exists. reset pulsed between edges -> f_pc=bfc00000 and f_valid=0 immediately, all BTB hits gone.
